// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: default widths, length-field
// width, bytes-per-word helper and the loader state encoding.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int DEF_PC_WIDTH          = 8;
  localparam int DEF_INSTRUCTION_WIDTH = 16;
  localparam int LEN_W                 = 16;

  // Bytes per instruction word; instruction width is a multiple of 8.
  function automatic int bpw(input int instr_width);
    return instr_width / 8;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK  = 3'd4,
`endif
    ST_FINISH = 3'd5
  } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// slave: the loader side; master: the byte source / memory side.
interface program_loader_if #(
  parameter int PC_WIDTH          = 8,
  parameter int INSTRUCTION_WIDTH = 16
) ();
  logic [7:0]                   in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic                         wr_en;
  logic [PC_WIDTH-1:0]          wr_addr;
  logic [INSTRUCTION_WIDTH-1:0] wr_data;

  modport slave  (input  in_data, in_valid,
                  output in_ready, wr_en, wr_addr, wr_data);
  modport master (output in_data, in_valid,
                  input  in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/byte_assembler.sv
// Collects BPW bytes (most significant first) into one word and pulses
// word_ready on the cycle after the final byte of a word is taken.
module byte_assembler #(
  parameter int BPW = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               byte_en,
  input  logic [7:0]         byte_in,
  output logic [8*BPW-1:0]   word,
  output logic               word_ready
);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BPW - 1);

  logic [8*BPW-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;

  // Shift bytes in and flag a completed word for exactly one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (byte_en) begin
      r_shift <= (r_shift << 8) | (8*BPW)'(byte_in);
      if (r_cnt == LAST_IDX) begin
        r_cnt   <= '0;
        r_ready <= 1'b1;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_ready <= 1'b0;
      end
    end else begin
      r_ready <= 1'b0;
    end
  end

  assign word       = r_shift;
  assign word_ready = r_ready;
endmodule

// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed byte stream, writes the words
// into instruction memory and holds the CPU while loading.
// Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int PC_WIDTH          = DEF_PC_WIDTH,
  parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  program_loader_if.slave     bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error
);
  localparam int BPW = bpw(INSTRUCTION_WIDTH);
  localparam int unsigned MAX_WORDS = 2 ** PC_WIDTH;
`ifdef LOADER_CHECKSUM_EN
  localparam state_e ST_POST_DATA = ST_CHECK;
`else
  localparam state_e ST_POST_DATA = ST_FINISH;
`endif

  state_e              r_state, state_n;
  logic [LEN_W-1:0]    r_len, len_n;
  // One extra bit so the counter never wraps after a full-memory load.
  logic [PC_WIDTH:0]   r_addr, addr_n;
  logic                r_error, err_n;
  logic                r_cpu_hold, hold_n;
  logic                r_done;
  logic                w_clear, w_accept, w_in_ready, w_byte_en;
  logic                w_word_ready, w_last_word;
  logic [LEN_W-1:0]    w_len_full;
  logic [INSTRUCTION_WIDTH-1:0] w_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          r_csum, csum_n;
`endif

  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_byte_en   = w_accept && (r_state == ST_DATA);
  assign w_len_full  = {r_len[15:8], bus.in_data};
  assign w_last_word = ((32'(r_addr) + 32'd1) == 32'(r_len));

  byte_assembler #(.BPW(BPW)) u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (w_clear),
    .byte_en    (w_byte_en),
    .byte_in    (bus.in_data),
    .word       (w_word),
    .word_ready (w_word_ready)
  );

  // Ready in the byte-consuming states, except during the write bubble.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_LEN_HI, ST_LEN_LO, ST_DATA: w_in_ready = !w_word_ready;
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK:                      w_in_ready = !w_word_ready;
`endif
      default:                       w_in_ready = 1'b0;
    endcase
  end

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_n = r_state;
    len_n   = r_len;
    addr_n  = r_addr;
    err_n   = r_error;
    w_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_n  = r_csum;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_LEN_HI;
          len_n   = '0;
          addr_n  = '0;
          err_n   = 1'b0;
          w_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_n  = 8'h00;
`endif
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LEN_HI: begin
        if (w_accept) begin
          len_n   = {bus.in_data, r_len[7:0]};
          state_n = ST_LEN_LO;
`ifdef LOADER_CHECKSUM_EN
          csum_n  = r_csum + bus.in_data;
`endif
        end else begin
          state_n = ST_LEN_HI;
        end
      end
      ST_LEN_LO: begin
        if (w_accept) begin
          len_n = w_len_full;
`ifdef LOADER_CHECKSUM_EN
          csum_n = r_csum + bus.in_data;
`endif
          if (w_len_full == 16'd0) begin
            state_n = ST_POST_DATA;
          end else if (32'(w_len_full) > MAX_WORDS) begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DATA;
          end
        end else begin
          state_n = ST_LEN_LO;
        end
      end
      ST_DATA: begin
        if (w_word_ready) begin
          addr_n = r_addr + (PC_WIDTH+1)'(1);
          if (w_last_word) begin
            state_n = ST_POST_DATA;
          end else begin
            state_n = ST_DATA;
          end
        end else if (w_accept) begin
          state_n = ST_DATA;
`ifdef LOADER_CHECKSUM_EN
          csum_n  = r_csum + bus.in_data;
`endif
        end else begin
          state_n = ST_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (w_accept) begin
          if (bus.in_data == r_csum) begin
            state_n = ST_FINISH;
          end else begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end else begin
          state_n = ST_CHECK;
        end
      end
`endif
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // CPU is held in every state that is still consuming the stream.
  always_comb begin
    hold_n = 1'b0;
    case (state_n)
      ST_LEN_HI, ST_LEN_LO, ST_DATA: hold_n = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK:                      hold_n = 1'b1;
`endif
      default:                       hold_n = 1'b0;
    endcase
  end

  // State and registered outputs; reset returns to IDLE at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_addr     <= '0;
      r_error    <= 1'b0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum     <= 8'h00;
`endif
    end else begin
      r_state    <= state_n;
      r_len      <= len_n;
      r_addr     <= addr_n;
      r_error    <= err_n;
      r_cpu_hold <= hold_n;
      r_done     <= (state_n == ST_FINISH);
`ifdef LOADER_CHECKSUM_EN
      r_csum     <= csum_n;
`endif
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.wr_en    = w_word_ready;
  assign bus.wr_addr  = r_addr[PC_WIDTH-1:0];
  assign bus.wr_data  = w_word;
  assign cpu_hold     = r_cpu_hold;
  assign done         = r_done;
  assign error        = r_error;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a transaction-level model builds
// the expected word writes, accepted-byte count at done, and final flags
// from each generated stream; a negedge monitor compares every write and
// done pulse against it. Honours LOADER_CHECKSUM_EN when defined.
module tb_program_loader;
  localparam int PCW = 8;
  localparam int IW  = 16;
  localparam int BPW = IW / 8;

  typedef struct packed {
    logic [PCW-1:0] addr;
    logic [IW-1:0]  data;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cpu_hold, done, error;

  program_loader_if #(.PC_WIDTH(PCW), .INSTRUCTION_WIDTH(IW)) bus ();

  program_loader #(.PC_WIDTH(PCW), .INSTRUCTION_WIDTH(IW)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  int  checks = 0;
  int  failures = 0;
  wr_t exp_q[$];
  wr_t log_q[$];
  wr_t mon_e;
  int  acc_cnt = 0;
  int  acc_base = 0;
  int  exp_bytes = 0;
  int  done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: big-endian packing of BPW bytes into one word.
  function automatic logic [IW-1:0] pack_word(input logic [7:0] b[$], input int first);
    logic [IW-1:0] w = '0;
    for (int k = 0; k < BPW; k++) w = (w << 8) | IW'(b[first + k]);
    return w;
  endfunction

  // Model: arithmetic sum of bytes modulo 256.
  function automatic logic [7:0] sum8(input logic [7:0] b[$]);
    int s = 0;
    foreach (b[i]) s += int'(b[i]);
    return 8'(s % 256);
  endfunction

  // Monitor: every write and every done pulse is checked against the model.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.in_valid && bus.in_ready) acc_cnt++;
      if (bus.wr_en) begin
        chk("wr_vs_in_ready", 32'(bus.in_ready), 32'd0);
        mon_e.addr = bus.wr_addr;
        mon_e.data = bus.wr_data;
        log_q.push_back(mon_e);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%h:%h expected=none", bus.wr_addr, bus.wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(mon_e.addr));
          chk("wr_data", 32'(bus.wr_data), 32'(mon_e.data));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_after_bytes", 32'(acc_cnt - acc_base), 32'(exp_bytes));
        chk("hold_in_done", 32'(cpu_hold), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer the stream; mode 0 = always valid, 1 = every other cycle, 2 = random.
  task automatic drive(input logic [7:0] s[$], input int mode, input int glitch_at);
    int   idx = 0;
    int   guard = 0;
    logic v;
    while (idx < s.size() && guard < 5000) begin
      guard++;
      case (mode)
        0:       v = 1'b1;
        1:       v = guard[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? s[idx] : 8'($urandom);
      start        = (glitch_at >= 0) && (idx == glitch_at);
      @(negedge clock);
      if (bus.in_valid && bus.in_ready) idx++;
      tick();
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;
    chk("stream_accepted", 32'(idx), 32'(s.size()));
  endtask

  task automatic run_load(input int n, input logic [7:0] data[$], input int mode,
                          input int glitch_at, input bit bad_csum);
    logic [7:0] s[$];
    wr_t        e;
    int         d0;
    bit         fits;
    bit         ok;
    fits = (n <= 2 ** PCW);
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    foreach (data[i]) s.push_back(data[i]);
`ifdef LOADER_CHECKSUM_EN
    if (fits) s.push_back(sum8(s) ^ (bad_csum ? 8'h01 : 8'h00));
`endif
    ok = fits && !bad_csum;
    exp_q.delete();
    log_q.delete();
    if (fits) begin
      for (int w = 0; w < n; w++) begin
        e.addr = PCW'(w);
        e.data = pack_word(data, w * BPW);
        exp_q.push_back(e);
      end
    end
    exp_bytes = s.size();
    d0 = done_cnt;
    start = 1'b1;
    acc_base = acc_cnt;
    tick();
    start = 1'b0;
    chk("hold_after_start", 32'(cpu_hold), 32'd1);
    drive(s, mode, glitch_at);
    for (int i = 0; i < 20 && cpu_hold; i++) tick();
    tick();
    tick();
    chk("hold_at_end", 32'(cpu_hold), 32'd0);
    chk("writes_missing", 32'(exp_q.size()), 32'd0);
    chk("done_pulses", 32'(done_cnt - d0), ok ? 32'd1 : 32'd0);
    chk("error_flag", 32'(error), ok ? 32'd0 : 32'd1);
  endtask

  task automatic check_three_words();
    chk("log_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("lit_w0", 32'({log_q[0].addr, log_q[0].data}), 32'h0000_1234);
      chk("lit_w1", 32'({log_q[1].addr, log_q[1].data}), 32'h0001_5678);
      chk("lit_w2", 32'({log_q[2].addr, log_q[2].data}), 32'h0002_9ABC);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
    chk({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
    chk({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold),     32'd0);
    chk({tag, "_done"},     32'(done),         32'd0);
    chk({tag, "_error"},    32'(error),        32'd0);
  endtask

  initial begin
    logic [7:0] d3[$];
    logic [7:0] dn[$];
    logic [7:0] pin[$];
    logic [7:0] part[$];
    wr_t        e;
    int         n;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check_outputs_zero("rst");
    reset = 1'b0;
    tick();
    check_outputs_zero("idle");

    // Pin the model with hand-computed values.
    pin = '{8'h12, 8'h34};
    chk("model_pack", 32'(pack_word(pin, 0)), 32'h0000_1234);
    pin = '{8'h00, 8'h01, 8'hAB, 8'hCD};
    chk("model_sum", 32'(sum8(pin)), 32'h0000_0079);

    // Three-word image, continuous and every-other-cycle valid.
    d3 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    run_load(3, d3, 0, -1, 1'b0);
    check_three_words();
    run_load(3, d3, 1, -1, 1'b0);
    check_three_words();

    // Empty image and oversized length.
    dn.delete();
    run_load(0, dn, 0, -1, 1'b0);
    chk("n0_no_writes", 32'(log_q.size()), 32'd0);
    run_load(257, dn, 0, -1, 1'b0);
    chk("n257_no_writes", 32'(log_q.size()), 32'd0);
    run_load(65535, dn, 2, -1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    pin = '{8'hAB, 8'hCD};
    run_load(1, pin, 0, -1, 1'b0);
    run_load(1, pin, 0, -1, 1'b1);
    chk("bad_csum_write", 32'(log_q.size()), 32'd1);
`endif

    // Start pulse held during DATA must be ignored.
    dn.delete();
    for (int i = 0; i < 4 * BPW; i++) dn.push_back(8'($urandom));
    run_load(4, dn, 0, 3, 1'b0);

    // Full-memory load: last write lands at the top address.
    dn.delete();
    for (int i = 0; i < (2 ** PCW) * BPW; i++) dn.push_back(8'($urandom));
    run_load(2 ** PCW, dn, 2, -1, 1'b0);
    chk("full_count", 32'(log_q.size()), 32'(2 ** PCW));
    if (log_q.size() > 0) chk("full_last_addr", 32'(log_q[log_q.size()-1].addr), 32'h0000_00FF);

    // Randomized loads.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 10);
      dn.delete();
      for (int i = 0; i < n * BPW; i++) dn.push_back(8'($urandom));
      run_load(n, dn, $urandom_range(0, 2), -1, 1'b0);
    end

    // Asynchronous reset after the 5th byte, then a clean reload.
    exp_q.delete();
    log_q.delete();
    e.addr = 8'h00;
    e.data = 16'h1234;
    exp_q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    part = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h56};
    drive(part, 0, -1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    chk("pre_rst_write", 32'(exp_q.size()), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    run_load(3, d3, 0, -1, 1'b0);
    check_three_words();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
